// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared FSM state and RV32I funct3 encodings for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Illegal width code or misaligned address; the range check needs DEPTH_WORDS and lives in the top.
  function automatic logic access_err(input logic is_store, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    if (is_store) illegal = (funct3 > F3_W);
    else          illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return illegal | misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane extraction with sign/zero extension and store lane merging
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'd0, byte_lane};
      F3_HU:   load_data = {16'd0, half_lane};
      default: load_data = '0;
    endcase

    store_word = word;
    case (funct3)
      F3_B: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding RV32I load/store unit with read-modify-write for SB/SH
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [31:0] mem_read_data
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, wdata_q, word_q;
  logic [2:0]  funct3_q;
  logic        is_store_q, err_q;
  logic        handshake, req_err;
  logic [31:0] load_data, store_word;

  assign handshake = req_valid & req_ready;
  assign req_err   = access_err(req_is_store, req_funct3, req_addr[1:0]) |
                     ({2'b00, req_addr[31:2]} >= $unsigned(DEPTH_WORDS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          if (req_err)                                state_d = S_RESP;
          else if (req_is_store && req_funct3 == F3_W) state_d = S_WRITE;
          else                                        state_d = S_READ;
        end
      end
      S_READ:  state_d = is_store_q ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
      word_q     <= '0;
    end else begin
      if (handshake) begin
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        funct3_q   <= req_funct3;
        is_store_q <= req_is_store;
        err_q      <= req_err;
      end
      if (state_q == S_READ) word_q <= mem_read_data;
    end
  end

  lsu_align u_align (
    .word       (word_q),
    .addr_lo    (addr_q[1:0]),
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // req_ready is gated by reset so it only rises once reset is released.
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    resp_err       = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    case (state_q)
      S_IDLE: req_ready = reset;
      S_READ: begin
        mem_read_en = 1'b1;
        mem_addr    = {addr_q[31:2], 2'b00};
      end
      S_WRITE: begin
        mem_write_en   = 1'b1;
        mem_addr       = {addr_q[31:2], 2'b00};
        mem_write_data = store_word;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || is_store_q) ? 32'd0 : load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a byte-level memory model
module tb_load_store_unit;

  localparam int DEPTH = 28;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_read_data;

  load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_store   (req_is_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          reads;
    int          writes;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    int          hs_cyc;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] dut_mem[DEPTH];
  logic [31:0] ref_mem[DEPTH];
  logic        preload = 1'b1;
  int          checks = 0, errors = 0;
  int          cyc = 0, rd_cnt = 0, wr_cnt = 0;
  int          issued = 0, aborted = 0, responses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    mem_read_data = '0;
    if (mem_addr[31:2] < 30'(DEPTH)) mem_read_data = dut_mem[mem_addr[6:2]];
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) dut_mem[i] <= ref_mem[i];
    end else if (mem_write_en && mem_addr[31:2] < 30'(DEPTH)) begin
      dut_mem[mem_addr[6:2]] <= mem_write_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: byte-addressed access with size/alignment rules and mask arithmetic on a word array.
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output exp_t e);
    int size, off, idx;
    bit illegal;
    logic [31:0] w, v, mask;
    illegal = 0;
    size = 1;
    if (st) begin
      if (f3 > 2) illegal = 1;
      else size = 1 << f3;
    end else begin
      case (f3)
        3'd0, 3'd4: size = 1;
        3'd1, 3'd5: size = 2;
        3'd2:       size = 4;
        default:    illegal = 1;
      endcase
    end
    off = int'(a % 4);
    e = '{err: 0, rdata: 0, lat: 1, reads: 0, writes: 0, wr_addr: 0, wr_data: 0, hs_cyc: 0};
    e.err = illegal || (a % size != 0) || ((a >> 2) >= DEPTH);
    if (e.err) return;
    idx = int'(a >> 2);
    w = ref_mem[idx];
    if (!st) begin
      v = w >> (8 * off);
      if (size == 1) begin
        v = v & 32'hff;
        if (f3 == 3'd0 && v[7]) v = v | 32'hffffff00;
      end else if (size == 2) begin
        v = v & 32'hffff;
        if (f3 == 3'd1 && v[15]) v = v | 32'hffff0000;
      end
      e.rdata = v;
      e.lat = 2;
      e.reads = 1;
    end else begin
      mask = (size == 4) ? 32'hffffffff : (((32'd1 << (8 * size)) - 1) << (8 * off));
      v = (w & ~mask) | ((wd << (8 * off)) & mask);
      ref_mem[idx] = v;
      e.lat = (size == 4) ? 2 : 3;
      e.reads = (size == 4) ? 0 : 1;
      e.writes = 1;
      e.wr_addr = idx * 4;
      e.wr_data = v;
    end
  endtask

  always @(negedge clk) begin
    check("strobe_exclusive", 32'(mem_read_en & mem_write_en), 0);
    if (!mem_read_en && !mem_write_en) begin
      check("idle_mem_addr", mem_addr, 0);
      check("idle_mem_wdata", mem_write_data, 0);
    end
    if (mem_read_en) rd_cnt++;
    if (mem_write_en) begin
      wr_cnt++;
      if (expq.size() == 0) fail_now("unexpected_write");
      else begin
        check("write_addr", mem_addr, expq[0].wr_addr);
        check("write_data", mem_write_data, expq[0].wr_data);
      end
    end
    if (resp_valid) begin
      responses++;
      if (expq.size() == 0) fail_now("unexpected_resp");
      else begin
        exp_t e;
        e = expq.pop_front();
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("resp_rdata", resp_rdata, e.rdata);
        check("latency", cyc - e.hs_cyc, e.lat);
        check("read_strobes", rd_cnt, e.reads);
        check("write_strobes", wr_cnt, e.writes);
      end
      rd_cnt = 0;
      wr_cnt = 0;
    end
  end

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
    exp_t e;
    int n = 0;
    req_is_store = st;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail_now("req_ready_timeout");
      req_valid = 1'b0;
      return;
    end
    model(st, f3, a, wd, e);
    e.hs_cyc = cyc;
    expq.push_back(e);
    issued++;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) fail_now("drain_timeout");
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] saved;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    ref_mem[2] = 32'h11223344;
    ref_mem[3] = 32'h8badf00d;

    #12;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_read_en", 32'(mem_read_en), 0);
    check("rst_write_en", 32'(mem_write_en), 0);
    check("rst_resp_rdata", resp_rdata, 0);
    @(negedge clk);
    preload = 1'b0;
    reset = 1'b1;
    #1 check("post_rst_req_ready", 32'(req_ready), 1);
    @(negedge clk);

    issue(0, 3'd0, 32'h0D, 0, 0);
    issue(0, 3'd4, 32'h0D, 0, 0);
    issue(1, 3'd1, 32'h0A, 32'h0000beef, 0);
    issue(0, 3'd2, 32'h06, 0, 0);
    issue(1, 3'd2, 32'h70, 32'hcafef00d, 0);
    issue(1, 3'd2, 32'h6C, 32'h12345678, 0);
    issue(0, 3'd2, 32'h08, 0, 0);
    drain();

    // Abort an SB in its WRITE cycle.
    saved = ref_mem[5];
    issue(1, 3'd0, 32'h16, $urandom, 0);
    for (int n = 0; n < 10 && !mem_write_en; n++) @(negedge clk);
    if (!mem_write_en) fail_now("sb_write_not_seen");
    #2 reset = 1'b0;
    #1;
    check("abort_write_en", 32'(mem_write_en), 0);
    check("abort_resp_valid", 32'(resp_valid), 0);
    check("abort_req_ready", 32'(req_ready), 0);
    expq.delete();
    rd_cnt = 0;
    wr_cnt = 0;
    ref_mem[5] = saved;
    aborted++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 check("abort_release_ready", 32'(req_ready), 1);
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      issue(i[0], 3'd2, 32'($urandom_range(0, DEPTH - 1)) * 4, $urandom, i != 9);
    drain();

    for (int i = 0; i < 300; i++)
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'($urandom_range(0, DEPTH * 4 + 11)), $urandom,
            (i != 299) && ($urandom_range(0, 3) == 0));
    drain();

    check("handshake_count", responses, issued - aborted);
    for (int i = 0; i < DEPTH; i++) check("final_mem", dut_mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 28, the number of 32-bit words in the attached data memory.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the core presents a request.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the unit accepts a request.
REQ-006 The block SHALL have port req_is_store, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_funct3, input, 3 bits: RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 The block SHALL have port req_addr, input, 32 bits: the byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: the store data, in the low-aligned lanes.
REQ-010 The block SHALL have port resp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-011 The block SHALL have port resp_rdata, output, 32 bits: the extended load result.
REQ-012 The block SHALL have port resp_err, output, 1 bit: misaligned, illegal funct3, or out of range.
REQ-013 The block SHALL have port mem_addr, output, 32 bits: the word-aligned byte address to data memory.
REQ-014 The block SHALL have port mem_write_data, output, 32 bits: the full word to write.
REQ-015 The block SHALL have port mem_read_en, output, 1 bit: the memory read strobe.
REQ-016 The block SHALL have port mem_write_en, output, 1 bit: the memory write strobe.
REQ-017 The block SHALL have port mem_read_data, input, 32 bits: combinational memory read data, valid in the same cycle as mem_read_en.

Function
REQ-018 The FSM SHALL have states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-019 On a handshake (req_valid & req_ready), the unit SHALL latch addr, funct3, is_store and wdata.
REQ-020 On a handshake, the unit SHALL compute err, and the next state SHALL be RESP if err, READ for a load, SB or SH, and WRITE for SW.
REQ-021 err SHALL be set for any of: load funct3 in {3,6,7}; store funct3 > 2; halfword access with addr[0] = 1; word access with addr[1:0] != 0; addr[31:2] >= DEPTH_WORDS.
REQ-022 In READ, the unit SHALL assert mem_read_en = 1, drive mem_addr = {addr[31:2], 2'b00}, and capture mem_read_data into a word register at the clock edge.
REQ-023 From READ, the next state SHALL be WRITE for a store and RESP for a load.
REQ-024 In WRITE, the unit SHALL assert mem_write_en = 1, drive mem_addr aligned, and drive mem_write_data as follows.
- SW: req_wdata.
- SH: the captured word with lane addr[1] replaced by wdata[15:0].
- SB: the captured word with byte lane addr[1:0] replaced by wdata[7:0].
REQ-025 From WRITE, the next state SHALL be RESP.
REQ-026 In RESP, resp_valid SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-027 In RESP, resp_rdata SHALL be the selected lane of the captured word, sign-extended (LB/LH) or zero-extended (LBU/LHU).
REQ-028 In RESP, resp_rdata SHALL be 0 for stores and when err = 1.
REQ-029 Latency SHALL be counted from the handshake edge to resp_valid:
- Load: 2 cycles.
- SW: 2 cycles.
- SB/SH: 3 cycles.
- err: 1 cycle.
REQ-030 An errored request SHALL never assert mem_read_en or mem_write_en.
REQ-031 mem_read_en and mem_write_en SHALL never be high in the same cycle.
REQ-032 Outside READ/WRITE, mem_addr and mem_write_data SHALL be 0.
REQ-033 A new request SHALL be accepted only in IDLE, so back-to-back requests are separated by at least one IDLE cycle after RESP.
REQ-034 req_valid in non-IDLE states SHALL be ignored; the core holds it until req_ready.

Reset
REQ-035 reset low SHALL immediately force state IDLE and all outputs to 0, except req_ready = 1 once reset is released.
REQ-036 The latched request and captured word SHALL also be cleared on reset.
REQ-037 Reset asserted mid-READ or mid-WRITE SHALL abort the transaction, with no response pulse.
REQ-038 A write strobe SHALL not persist past the reset assertion.

Structure
REQ-039 Package lsu_pkg SHALL hold the FSM state enum and the funct3 constants (F3_B = 0, F3_H = 1, F3_W = 2, F3_BU = 4, F3_HU = 5).
REQ-040 Sub-module lsu_align (combinational) SHALL perform lane extraction with sign/zero extension and store-lane merging; the FSM and registers stay in load_store_unit.

Verification
REQ-041 Memory word 3 = 32'h8badf00d; LB at addr 0x0D -> resp_rdata = 32'hfffffff0 two cycles after the handshake; LBU at 0x0D -> 32'h000000f0.
REQ-042 Memory word 2 = 32'h11223344; SH addr 0x0A, wdata 32'h0000beef -> one READ then one WRITE, mem_write_data = 32'hbeef3344, resp_valid three cycles after the handshake.
REQ-043 LW at addr 0x06 -> resp_err = 1 and resp_rdata = 0 one cycle after the handshake; mem_read_en stays 0 throughout.
REQ-044 SW at addr 0x70 (word 28, DEPTH_WORDS = 28) -> resp_err = 1 and no mem_write_en pulse; SW at 0x6C -> the write occurs with mem_addr = 0x6C.
REQ-045 Reset asserted during WRITE of an SB -> mem_write_en drops immediately, resp_valid never pulses, req_ready = 1 after release.
REQ-046 req_valid held high continuously with alternating LW/SW -> exactly one handshake per IDLE visit and no overlapping strobes.
